// File: rtl/execute_stage_if.sv
// execute_stage_if: bundles the signals of the execute stage.
//   E-stage inputs : operands, immediate, PC values, control fields from the
//                    decode/execute register, forwarding selects, ResultW.
//   E-stage outputs: ZeroE, PCTargetE, StallMD.
//   M-stage outputs: execute/memory pipeline register contents.
// The pipeline side uses modport master. The execute stage uses modport slave.
interface execute_stage_if;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        ZeroE;
  logic [31:0] PCTargetE;
  logic        StallMD;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;

  modport master (
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, RegWriteE, MemWriteE,
           ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE, funct3E,
           ForwardAE, ForwardBE, ResultW,
    input  ZeroE, PCTargetE, StallMD, ALUResultM, WriteDataM, PCPlus4M,
           RdM, RegWriteM, MemWriteM, ResultSrcM
  );

  modport slave (
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, RegWriteE, MemWriteE,
           ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE, funct3E,
           ForwardAE, ForwardBE, ResultW,
    output ZeroE, PCTargetE, StallMD, ALUResultM, WriteDataM, PCPlus4M,
           RdM, RegWriteM, MemWriteM, ResultSrcM
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: RV32 execute stage.
// It contains the operand forwarding muxes, the base ALU, and the branch
// compare and target adder. It also contains an iterative RV32M
// multiply/divide unit that takes 34 cycles in E and stalls the front end.
// The execute/memory pipeline register is at the output.
// Ports:
//   clk, rst : clock and synchronous active-high reset.
//   bus      : execute_stage_if.slave. It carries the E-stage inputs, the
//              ZeroE/PCTargetE/StallMD outputs and the M-register outputs.
// Base ALU encoding for ALUControlE:
//   00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT,
//   00110 SLTU, 00111 SLL, 01000 SRL, 01001 SRA, 01010 pass SrcB (LUI).
//   11xxx selects an M op. Any other code gives 0.
module execute_stage #(
  parameter int DATA_W = 32,  // only 32 is supported
  parameter bit FWD_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} md_state_e;

  md_state_e         state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, dz_q, dz_d;
  logic [DATA_W-1:0] alu_result_m_q, alu_result_m_d, write_data_m_q, write_data_m_d;
  logic [DATA_W-1:0] pc_plus4_m_q, pc_plus4_m_d;
  logic [4:0]        rd_m_q, rd_m_d;
  logic              reg_write_m_q, reg_write_m_d, mem_write_m_q, mem_write_m_d;
  logic [1:0]        result_src_m_q, result_src_m_d;

  logic [DATA_W-1:0] fwd_a, fwd_b, src_b, base_result, m_result, alu_result_e;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic              is_m, stall, zero, a_signed, b_signed, neg_a, neg_b;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod, prod_s;
  logic              unused_ok;

  // BranchE/JumpE are consumed by the decode/execute register (PCSrcE), not here.
  assign unused_ok = &{1'b0, bus.BranchE, bus.JumpE};

  // Forwarding muxes. Codes 00 and 11 both pick the register file value.
  always_comb begin
    fwd_a = bus.RD1E;
    fwd_b = bus.RD2E;
    if (FWD_EN) begin
      case (bus.ForwardAE)
        2'b01:   fwd_a = bus.ResultW;
        2'b10:   fwd_a = alu_result_m_q;
        default: fwd_a = bus.RD1E;
      endcase
      case (bus.ForwardBE)
        2'b01:   fwd_b = bus.ResultW;
        2'b10:   fwd_b = alu_result_m_q;
        default: fwd_b = bus.RD2E;
      endcase
    end else begin
      fwd_a = bus.RD1E;
      fwd_b = bus.RD2E;
    end
  end

  assign src_b         = bus.ALUSrcE ? bus.ImmExtE : fwd_b;
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
  assign is_m          = (bus.ALUControlE[4:3] == 2'b11);
  // The stall is raised combinationally in the capture cycle so that F/D/E hold at once.
  assign stall         = ((state_q == IDLE) && is_m) || (state_q == RUN);
  assign bus.StallMD   = stall;
  assign bus.ZeroE     = zero;

  // Branch condition, selected by funct3E on the forwarded operands.
  always_comb begin
    case (bus.funct3E)
      3'b000:  zero = (fwd_a == fwd_b);
      3'b001:  zero = (fwd_a != fwd_b);
      3'b100:  zero = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  zero = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  zero = (fwd_a <  fwd_b);
      3'b111:  zero = (fwd_a >= fwd_b);
      default: zero = 1'b0;
    endcase
  end

  // Base ALU.
  always_comb begin
    case (bus.ALUControlE)
      5'b00000: base_result = fwd_a + src_b;
      5'b00001: base_result = fwd_a - src_b;
      5'b00010: base_result = fwd_a & src_b;
      5'b00011: base_result = fwd_a | src_b;
      5'b00100: base_result = fwd_a ^ src_b;
      5'b00101: base_result = {31'd0, $signed(fwd_a) < $signed(src_b)};
      5'b00110: base_result = {31'd0, fwd_a < src_b};
      5'b00111: base_result = fwd_a << src_b[4:0];
      5'b01000: base_result = fwd_a >> src_b[4:0];
      5'b01001: base_result = $signed(fwd_a) >>> src_b[4:0];
      5'b01010: base_result = src_b;
      default:  base_result = 32'd0;
    endcase
  end

  // The unit works on magnitudes. Signed ops record the operand signs and
  // fix the sign of the result in DONE.
  assign a_signed = (bus.ALUControlE[2:0] == 3'b001) || (bus.ALUControlE[2:0] == 3'b010) ||
                    (bus.ALUControlE[2:0] == 3'b100) || (bus.ALUControlE[2:0] == 3'b110);
  assign b_signed = (bus.ALUControlE[2:0] == 3'b001) || (bus.ALUControlE[2:0] == 3'b100) ||
                    (bus.ALUControlE[2:0] == 3'b110);
  assign neg_a    = a_signed && fwd_a[31];
  assign neg_b    = b_signed && fwd_b[31];
  assign mag_a    = neg_a ? (~fwd_a + 32'd1) : fwd_a;
  assign mag_b    = neg_b ? (~fwd_b + 32'd1) : fwd_b;

  // Multiply step: {hi,lo} shifts right and the multiplicand is added when lo[0] is set.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
  // Restoring divide step: {rem,dividend} shifts left and a trial subtract sets the quotient bit.
  assign div_shift = {hi_q, lo_q[31]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // M result with sign correction. Divide by zero forces the quotient to all ones.
  // The remainder already equals the dividend in that case.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (~prod + 64'd1) : prod;
    case (op_q)
      3'b000:                 m_result = prod_s[31:0];
      3'b001, 3'b010, 3'b011: m_result = prod_s[63:32];
      3'b100, 3'b101:         m_result = dz_q ? 32'hFFFF_FFFF : (neg_q ? (~lo_q + 32'd1) : lo_q);
      default:                m_result = neg_q ? (~hi_q + 32'd1) : hi_q;
    endcase
  end

  assign alu_result_e = (state_q == DONE) ? m_result : base_result;

  // Next state for the mul/div FSM and its datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (is_m) begin
          op_d    = bus.ALUControlE[2:0];
          hi_d    = 32'd0;
          cnt_d   = 6'd0;
          state_d = RUN;
          if (bus.ALUControlE[2]) begin
            lo_d   = mag_a;
            opnd_d = mag_b;
            // A remainder takes the sign of the dividend. A quotient takes the xor of both signs.
            neg_d  = bus.ALUControlE[1] ? neg_a : (neg_a ^ neg_b);
            dz_d   = (fwd_b == 32'd0);
          end else begin
            lo_d   = mag_b;
            opnd_d = mag_a;
            neg_d  = neg_a ^ neg_b;
            dz_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (op_q[2]) begin
          hi_d = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
          lo_d = {lo_q[30:0], ~div_diff[32]};
        end else begin
          hi_d = mul_sum[32:1];
          lo_d = {mul_sum[0], lo_q[31:1]};
        end
        cnt_d   = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd31) ? DONE : RUN;
      end
      DONE: begin
        cnt_d   = 6'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 6'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Next value for the execute/memory register. A stall loads a bubble.
  always_comb begin
    if (stall) begin
      alu_result_m_d = 32'd0;
      write_data_m_d = 32'd0;
      pc_plus4_m_d   = 32'd0;
      rd_m_d         = 5'd0;
      reg_write_m_d  = 1'b0;
      mem_write_m_d  = 1'b0;
      result_src_m_d = 2'b00;
    end else begin
      alu_result_m_d = alu_result_e;
      write_data_m_d = fwd_b;
      pc_plus4_m_d   = bus.PCPlus4E;
      rd_m_d         = bus.RdE;
      reg_write_m_d  = bus.RegWriteE;
      mem_write_m_d  = bus.MemWriteE;
      result_src_m_d = bus.ResultSrcE;
    end
  end

  // All state registers. Reset aborts any mul/div in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 6'd0;
      hi_q           <= 32'd0;
      lo_q           <= 32'd0;
      opnd_q         <= 32'd0;
      op_q           <= 3'd0;
      neg_q          <= 1'b0;
      dz_q           <= 1'b0;
      alu_result_m_q <= 32'd0;
      write_data_m_q <= 32'd0;
      pc_plus4_m_q   <= 32'd0;
      rd_m_q         <= 5'd0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      opnd_q         <= opnd_d;
      op_q           <= op_d;
      neg_q          <= neg_d;
      dz_q           <= dz_d;
      alu_result_m_q <= alu_result_m_d;
      write_data_m_q <= write_data_m_d;
      pc_plus4_m_q   <= pc_plus4_m_d;
      rd_m_q         <= rd_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_src_m_q <= result_src_m_d;
    end
  end

  assign bus.ALUResultM = alu_result_m_q;
  assign bus.WriteDataM = write_data_m_q;
  assign bus.PCPlus4M   = pc_plus4_m_q;
  assign bus.RdM        = rd_m_q;
  assign bus.RegWriteM  = reg_write_m_q;
  assign bus.MemWriteM  = mem_write_m_q;
  assign bus.ResultSrcM = result_src_m_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage sitting directly downstream of the decode/execute pipeline register; consumes its E-stage outputs.
- Contents: operand forwarding muxes, the existing base ALU (combinational), branch-condition and target evaluation, an iterative RV32M multiply/divide FSM that stalls the front end, and the execute/memory pipeline register.
- ZeroE feeds back to the decode/execute register, which forms PCSrcE = (ZeroE & BranchE) | JumpE.

Parameters:
- DATA_W, 32, datapath width; only 32 supported.
- FWD_EN, 1, when 0 the forwarding muxes always select RD1E/RD2E.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- RD1E, RD2E  in  32  register operands.
- ImmExtE, PCE, PCPlus4E  in  32 each.
- RdE  in  5.
- RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  in  1 each.
- ResultSrcE  in  2.
- ALUControlE  in  5.
- funct3E  in  3.
- ForwardAE, ForwardBE  in  2  00 = RDxE, 01 = ResultW, 10 = ALUResultM, 11 = RDxE.
- ResultW  in  32  writeback forwarding value.
- ZeroE  out  1  branch condition true.
- PCTargetE  out  32  PCE + ImmExtE.
- StallMD  out  1  mul/div busy; hazard unit stalls F/D/E.
- ALUResultM, WriteDataM, PCPlus4M  out  32.
- RdM  out  5.
- RegWriteM, MemWriteM  out  1.
- ResultSrcM  out  2.

Behaviour:
- Reset: rst is synchronous, active-high, and sampled on posedge clk.
  - All M-register outputs go to 0.
  - FSM goes to IDLE, iteration counter to 0, StallMD to 0.
  - A reset mid-operation aborts the operation with no writeback.
- Operands:
  - SrcAE = fwdA.
  - WriteDataE = fwdB.
  - SrcBE = ALUSrcE ? ImmExtE : fwdB.
- ZeroE (combinational), selected by funct3E on fwdA vs fwdB:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - Other codes give 0.
- PCTargetE is combinational, mod 2^32.
- M-op decode:
  - ALUControlE[4:3] == 2'b11 selects an M op.
  - ALUControlE[2:0]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - All other ALUControlE values go to the base ALU, zero cycles of extra latency.
- FSM states: IDLE, RUN, DONE.
  - IDLE with an M op in E (cycle t): capture fwdA, fwdB and op into internal registers; StallMD = 1 combinationally this cycle; go to RUN.
  - RUN (t+1..t+32): one shift-add / restoring-divide step per cycle; StallMD = 1; after the 32nd step go to DONE.
  - DONE (t+33): StallMD = 0; the M result drives ALUResultE; the M-register latches normally at the end of the cycle; go to IDLE.
  - Fixed latency: 34 cycles in E for every M op.
- Operand capture: values are taken only at cycle t. Later changes on RD1E/RD2E/forwarding inputs during RUN are ignored.
- Bubbles: while StallMD = 1, the M-register loads a bubble (RegWriteM = 0, MemWriteM = 0, other fields don't-care but held at 0).
- Signed handling: signs are corrected on capture and result (two's complement magnitude).
  - MULH* returns the upper 32 bits of the 64-bit product.
- Corner cases (ISA-defined, same latency):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0.
- Non-M ops: the M-register loads the E values every cycle; there is no enable other than the stall bubble.
- The block has no flush input. The decode/execute register guarantees that an M op in E is never flushed.

Test Plan:
- Reset mid-RUN: assert rst at cycle t+10 -> next cycle StallMD = 0, all M outputs 0, FSM IDLE; a following ADD passes normally.
- ADD with ForwardAE = 10 (ALUResultM = 5), RD2E = 7 -> ALUResultM = 12, RegWriteM = 1 one cycle later.
- BLT with fwdA = 0xFFFFFFFF, fwdB = 1 -> ZeroE = 1.
  - BLTU with the same operands -> ZeroE = 0.
  - PCE = 0x100, ImmExtE = 0xFFFFFFF0 -> PCTargetE = 0xF0.
- MUL 0xFFFFFFFE * 3 -> StallMD high for exactly 33 cycles, 33 bubbles in M, then ALUResultM = 0xFFFFFFFA.
  - MULH with the same operands -> 0xFFFFFFFF.
  - MULHU with the same operands -> 0x00000002.
- DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU x/0 -> 0xFFFFFFFF.
  - REM 0x80000000 % 0xFFFFFFFF -> 0.
- Operand isolation: change RD1E and ResultW every cycle during RUN -> result equals the values captured at cycle t.
  - A back-to-back second M op starts only after DONE (total 68 stall-free-to-result cycles).
